// File: rtl/expu_schraudolph_pipe.sv
// Schraudolph exponential front-end: e^x ~= 2^(x*log2e).
// The integer part of x*log2e (fixed point) becomes the exponent field and
// the fractional part becomes the mantissa. The result is uncorrected; the
// mantissa-correction stage that follows refines it.
// The whole conversion is combinational ahead of the first register; the
// remaining PIPE_REGS-1 stages are plain elastic skid-free pipeline slots.
module expu_schraudolph_pipe #(
  parameter int FPFORMAT       = 0,   // 0: BF16, 1: FP16, 2: FP32
  parameter int LOG2E_FRACTION = 14,
  parameter int GUARD_BITS     = 2,
  parameter int PIPE_REGS      = 2,
  localparam int E     = (FPFORMAT == 1) ? 5 : 8,
  localparam int M     = (FPFORMAT == 1) ? 10 : (FPFORMAT == 2) ? 23 : 7,
  localparam int WIDTH = 1 + E + M
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] op_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] res_o,
  output logic             valid_o,
  input  logic             ready_i
);

  localparam int BIAS  = (1 << (E - 1)) - 1;
  localparam int LOG2E = int'(1.4426950409 * (2.0 ** LOG2E_FRACTION));
  localparam int SW    = M + 1;                 // significand with hidden one
  localparam int CW    = LOG2E_FRACTION + 1;    // log2(e) constant width
  localparam int PW    = SW + CW;               // product width
  localparam int XW    = PW + E - 1;            // room for the largest left shift
  localparam int FB    = M + GUARD_BITS;        // fixed-point fraction bits
  localparam int FW    = E + 1 + FB;            // signed fixed-point width

  // Right-shift amount that aligns the product for exponent field e is
  // RSH_BASE - e; it is non-negative for every non-saturating exponent.
  localparam logic [31:0]      RSH_BASE = 32'(BIAS + E - 1 + M + LOG2E_FRACTION - FB);
  localparam logic [CW-1:0]    LOG2E_C  = CW'(LOG2E);
  localparam logic [E-1:0]     EXP_ONES = '1;
  localparam logic [E-1:0]     EXP_BIG  = E'(BIAS + E);
  localparam logic [E+1:0]     BIAS_X   = (E + 2)'(BIAS);
  localparam logic [E:0]       EXP_MAX  = {1'b0, {E{1'b1}}};
  localparam logic [WIDTH-1:0] RES_NAN  = {1'b0, EXP_ONES, 1'b1, {(M - 1){1'b0}}};
  localparam logic [WIDTH-1:0] RES_INF  = {1'b0, EXP_ONES, {M{1'b0}}};
  localparam logic [WIDTH-1:0] RES_ZERO = '0;
  localparam logic [WIDTH-1:0] RES_ONE  = {1'b0, E'(BIAS), {M{1'b0}}};

  logic                    w_sign;
  logic [E-1:0]            w_exp;
  logic [M-1:0]            w_man;
  logic [PW-1:0]           w_prod;
  logic [XW-1:0]           w_a_ext;
  logic [XW-1:0]           w_a;
  logic [31:0]             w_rsh;
  logic                    w_a_big;
  logic [FW-1:0]           w_fix;
  logic signed [E+1:0]     w_exp_out;
  logic [WIDTH-1:0]        w_res;

  logic [PIPE_REGS-1:0]    r_valid;
  logic [WIDTH-1:0]        r_data [PIPE_REGS];
  logic [PIPE_REGS:0]      w_ready;
  logic [PIPE_REGS-1:0]    w_in_valid;
  logic [WIDTH-1:0]        w_in_data [PIPE_REGS];

  // Float -> fixed-point x*log2e -> packed 2^k * (1 + f), with special cases.
  always_comb begin
    w_sign  = op_i[WIDTH-1];
    w_exp   = op_i[WIDTH-2:M];
    w_man   = op_i[M-1:0];
    w_prod  = PW'({1'b1, w_man}) * PW'(LOG2E_C);
    w_a_ext = {w_prod, {(E - 1){1'b0}}};
    w_rsh   = RSH_BASE - 32'(w_exp);
    w_a     = w_a_ext >> w_rsh;
    // |x| >= 2^E always gives |x|*log2e >= 2^E; otherwise test the magnitude.
    w_a_big = (w_exp >= EXP_BIG) || (|w_a[XW-1:FW-1]);
    w_fix   = w_sign ? (FW'(0) - w_a[FW-1:0]) : w_a[FW-1:0];
    // Arithmetic integer part k is the upper slice of the two's-complement value.
    w_exp_out = $signed(BIAS_X) + $signed({w_fix[FW-1], w_fix[FW-1:FB]});

    if (w_exp == EXP_ONES && w_man != '0)
      w_res = RES_NAN;
    else if (w_exp == EXP_ONES)
      w_res = w_sign ? RES_ZERO : RES_INF;
    else if (w_exp == '0)
      w_res = RES_ONE;
    else if (w_a_big)
      w_res = w_sign ? RES_ZERO : RES_INF;
    else if (w_exp_out[E+1] || w_exp_out == '0)
      w_res = RES_ZERO;
    else if (w_exp_out[E:0] >= EXP_MAX)
      w_res = RES_INF;
    else
      w_res = {1'b0, w_exp_out[E-1:0], w_fix[FB-1:GUARD_BITS]};
  end

  // Backpressure chain from the output back to ready_o, plus stage inputs.
  always_comb begin
    logic rdy;
    rdy        = ready_i;
    w_ready    = '0;
    w_ready[PIPE_REGS] = ready_i;
    w_in_valid = '0;
    for (int i = PIPE_REGS - 1; i >= 0; i--) begin
      w_ready[i] = ~r_valid[i] | rdy;
      rdy        = w_ready[i];
    end
    w_in_valid[0] = valid_i;
    w_in_data[0]  = w_res;
    for (int i = 1; i < PIPE_REGS; i++) begin
      w_in_valid[i] = r_valid[i-1];
      w_in_data[i]  = r_data[i-1];
    end
  end

  // Stage registers: valids obey clear and backpressure, data holds when stalled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= '0;
      for (int i = 0; i < PIPE_REGS; i++) r_data[i] <= '0;
    end else begin
      for (int i = 0; i < PIPE_REGS; i++) begin
        if (clear_i)
          r_valid[i] <= 1'b0;
        else if (w_ready[i])
          r_valid[i] <= w_in_valid[i];
        if (w_ready[i] && w_in_valid[i])
          r_data[i] <= w_in_data[i];
      end
    end
  end

  assign ready_o = w_ready[0];
  assign valid_o = r_valid[PIPE_REGS-1];
  assign res_o   = r_data[PIPE_REGS-1];

endmodule

// File: tb/tb_expu_schraudolph_pipe.sv
// Bench for expu_schraudolph_pipe (BF16, PIPE_REGS=2): directed vectors,
// stall/clear/async-reset scenarios and randomized traffic against a
// real-arithmetic reference model with an in-order expected-result queue.
module tb_expu_schraudolph_pipe;

  localparam int PIPE_REGS = 2;

  logic        clk_i   = 1'b0;
  logic        rst_i   = 1'b0;
  logic        clear_i = 1'b0;
  logic [15:0] op_i    = '0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [15:0] res_o;
  logic        valid_o;
  logic        ready_i = 1'b1;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  logic [15:0] cur_exp  = '0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_res   = '0;
  bit          saw_ready_low = 1'b0;
  int          n_out = 0;

  expu_schraudolph_pipe #(
    .FPFORMAT(0), .LOG2E_FRACTION(14), .GUARD_BITS(2), .PIPE_REGS(PIPE_REGS)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .op_i(op_i),
    .valid_i(valid_i), .ready_o(ready_o), .res_o(res_o),
    .valid_o(valid_o), .ready_i(ready_i)
  );

  always #5 clk_i = ~clk_i;

  // e^x ~= 2^(x*log2e) evaluated with reals; every step is exact in double.
  function automatic logic [15:0] model(input logic [15:0] x);
    int     e = int'(x[14:7]);
    int     m = int'(x[6:0]);
    bit     s = x[15];
    real    a;
    longint afix, f, k, fr, ex;
    if (e == 255 && m != 0) return 16'h7FC0;
    if (e == 255) return s ? 16'h0000 : 16'h7F80;
    if (e == 0) return 16'h3F80;
    a = real'(128 + m) * 23637.0 / 2097152.0;
    for (int i = 0; i < e - 127; i++) a = a * 2.0;
    for (int i = 0; i < 127 - e; i++) a = a / 2.0;
    if (a >= 256.0) return s ? 16'h0000 : 16'h7F80;
    afix = longint'($floor(a * 512.0));
    f    = s ? -afix : afix;
    k    = longint'($floor(real'(f) / 512.0));
    fr   = f - k * 512;
    ex   = 127 + k;
    if (ex <= 0) return 16'h0000;
    if (ex >= 255) return 16'h7F80;
    return {1'b0, 8'(ex), 7'(fr >> 2)};
  endfunction

  function automatic logic [15:0] rand_op();
    logic [15:0] x;
    x = 16'($urandom);
    if ($urandom_range(0, 3) != 0) x[14:7] = 8'($urandom_range(112, 136));
    if ($urandom_range(0, 3) != 0) x[15] = 1'b1;
    return x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, expv);
    end
  endtask

  // One clock: sample at negedge, score the output, record accepted input,
  // then advance to just after the next rising edge.
  task automatic cycle(output bit acc);
    logic [15:0] e;
    @(negedge clk_i);
    if (prev_stall) begin
      chk("stall_valid_hold", valid_o, 1);
      chk("stall_data_hold", res_o, prev_res);
    end
    if (!ready_o) saw_ready_low = 1'b1;
    if (valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL extra_output observed=%0h expected=none", res_o);
      end else begin
        e = exp_q.pop_front();
        chk("res_o", res_o, e);
        n_out++;
      end
    end
    prev_stall = valid_o && !ready_i;
    prev_res   = res_o;
    acc = valid_i && ready_o && !clear_i;
    if (clear_i) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else if (acc) begin
      exp_q.push_back(cur_exp);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] e);
    bit acc;
    int n;
    op_i = x; cur_exp = e; valid_i = 1'b1;
    acc = 1'b0; n = 0;
    while (!acc && n < 50) begin
      cycle(acc);
      n++;
    end
    chk("send_accept", acc, 1);
    valid_i = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int n;
    valid_i = 1'b0; ready_i = 1'b1; n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      cycle(acc);
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  logic [15:0] svec [8] = '{16'hBF80, 16'h3F80, 16'hC000, 16'h4000,
                            16'hBF00, 16'h3E80, 16'hC1A0, 16'h0000};

  initial begin
    bit acc;
    int lat, n0, cyc, n_sent;

    // Reset state
    #1 rst_i = 1'b1;
    #2;
    chk("rst_valid_o", valid_o, 0);
    chk("rst_res_o", res_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    #1;
    chk("rst_ready_o", ready_o, 1);

    // First-result latency
    ready_i = 1'b1;
    op_i = 16'h0000; cur_exp = 16'h3F80; valid_i = 1'b1;
    cycle(acc);
    chk("lat_accept", acc, 1);
    valid_i = 1'b0;
    lat = 0; n0 = n_out;
    while (n_out == n0 && lat < 20) begin
      cycle(acc);
      lat++;
    end
    chk("latency", lat, PIPE_REGS);

    // Directed values
    send(16'h8001, 16'h3F80);
    send(16'hBF80, 16'h3EC7);
    send(16'h3F80, 16'h4038);
    send(16'hC300, 16'h0000);
    send(16'h4300, 16'h7F80);
    send(16'h7FC1, 16'h7FC0);
    send(16'hFF80, 16'h0000);
    send(16'h7F80, 16'h7F80);
    drain();

    // Eight back-to-back inputs with ready_i low for cycles 3..5
    saw_ready_low = 1'b0; n0 = n_out; n_sent = 0; cyc = 0;
    while ((n_sent < 8 || exp_q.size() > 0) && cyc < 60) begin
      valid_i = (n_sent < 8);
      op_i    = svec[n_sent % 8];
      cur_exp = model(op_i);
      ready_i = !(cyc >= 3 && cyc <= 5);
      cycle(acc);
      if (acc) n_sent++;
      cyc++;
    end
    valid_i = 1'b0; ready_i = 1'b1;
    chk("stream_ready_dropped", saw_ready_low, 1);
    chk("stream_out_count", n_out - n0, 8);

    // Clear with the pipe full and an input offered at the same time
    ready_i = 1'b0;
    send(16'hBF80, 16'h3EC7);
    send(16'h3F80, 16'h4038);
    clear_i = 1'b1; valid_i = 1'b1; op_i = 16'hC000; cur_exp = model(16'hC000);
    ready_i = 1'b1;
    cycle(acc);
    clear_i = 1'b0; valid_i = 1'b0;
    @(negedge clk_i);
    chk("clear_valid_o", valid_o, 0);
    @(posedge clk_i); #1;
    n0 = n_out;
    send(16'h4000, model(16'h4000));
    drain();
    chk("post_clear_out_count", n_out - n0, 1);

    // Asynchronous reset between edges while data is in flight
    ready_i = 1'b0;
    send(16'hBF00, model(16'hBF00));
    send(16'h3E80, model(16'h3E80));
    chk("pre_rst_valid_o", valid_o, 1);
    #2 rst_i = 1'b1;
    #1;
    chk("async_rst_valid_o", valid_o, 0);
    chk("async_rst_res_o", res_o, 0);
    exp_q.delete();
    prev_stall = 1'b0;
    @(posedge clk_i); #3;
    rst_i = 1'b0;
    #1;
    chk("post_rst_ready_o", ready_o, 1);
    ready_i = 1'b1;
    n0 = n_out;
    send(16'hBF80, 16'h3EC7);
    drain();
    chk("post_rst_out_count", n_out - n0, 1);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      valid_i = ($urandom_range(0, 9) < 7);
      op_i    = rand_op();
      cur_exp = model(op_i);
      ready_i = ($urandom_range(0, 9) < 7);
      cycle(acc);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/expu_schraudolph_pipe.md
Name: expu_schraudolph_pipe

Overview:
- Pipelined front-end of the exponential unit: computes the Schraudolph approximation e^x ≈ 2^(x·log2e).
- Converts x·log2(e) to fixed point and places its integer part in the exponent field and its fractional part in the mantissa field.
- Output feeds the combinational mantissa-correction stage that follows it in the EXPU.
- Elastic valid/ready pipeline, one result per cycle, inputs are typically ≤0 after softmax max-subtraction.

Parameters:
FPFORMAT, FPFORMAT_IN (BF16), input/output float format; WIDTH = fp_width(FPFORMAT), M = man_bits, E = exp_bits, BIAS = 2^(E-1)-1
LOG2E_FRACTION, 14, fraction bits of log2(e) constant; LOG2E = int'(1.4426950409·2^LOG2E_FRACTION) (23637 at default)
GUARD_BITS, 2, extra fraction bits kept below M in the fixed-point value
PIPE_REGS, 2, number of register stages (≥1), equals latency

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
clear_i  in  1  synchronous flush: all stage valids cleared
op_i  in  WIDTH  input float x
valid_i  in  1  op_i valid
ready_o  out  1  block accepts op_i this cycle
res_o  out  WIDTH  approximated e^x (uncorrected)
valid_o  out  1  res_o valid
ready_i  in  1  downstream accepts res_o

Behaviour:
- Clock/reset: one clock clk_i; reset rst_i asynchronous, active-high.
- Reset: all stage valids 0, data registers 0; valid_o=0, res_o=0. ready_o=1 once reset deasserts. Reset mid-operation discards all in-flight data.
- Handshake: transfer on valid && ready at each side. Stage i captures when ~valid[i] | ready[i+1]; last stage ready = ready_i. ready_o = ~valid[0] | ready[1] is combinational through the chain.
  - Data in a stalled stage holds stable; valid_o never drops without a transfer.
  - Latency PIPE_REGS cycles with ready_i=1; throughput 1/cycle; no bubbles when full and ready_i=1.
- clear_i: clears all valids next edge; has priority over a simultaneous input transfer (that input is dropped); ready_o unaffected.
- Arithmetic (split across stages; the split is free, results bit-exact):
  - A = ({1,mant}·LOG2E) aligned by (exp−BIAS).
  - Truncated toward zero to Q<E+1.(M+GUARD_BITS)>.
  - Fixed-point F = sign ? −A : A, two's complement.
  - k = floor(F) (arithmetic integer part), f = F − k.
  - Output mantissa = f >> GUARD_BITS (top M fraction bits, truncated). Output exponent = BIAS + k.
- Special cases, in priority order:
  - NaN in → canonical quiet NaN (0x7FC0 for BF16).
  - −Inf → +0.
  - +Inf → +Inf.
  - Zero or denormal exponent field → 1.0 (sign 0, exp BIAS, mant 0).
  - |x|·log2e ≥ 2^E (exp−BIAS ≥ E−1 early-detect allowed only if exact) → negative: +0, positive: +Inf.
  - BIAS+k ≤ 0 → +0 (no denormal outputs).
  - BIAS+k ≥ 2^E−1 → +Inf.
- Output sign always 0 except NaN.
- No internal overflow: intermediate widths sized for the largest non-saturating case.

Test Plan:
- Reset then x=0x0000, valid_i=1, ready_i=1 → after PIPE_REGS cycles valid_o=1, res_o=0x3F80; 0x8001 (denormal) → 0x3F80.
- x=0xBF80 (−1.0) → res_o=0x3EC7 (k=−2, mant 71); x=0x3F80 (+1.0) → res_o=0x4038.
- x=0xC300 (−128) → 0x0000; x=0x4300 (+128) → 0x7F80; 0x7FC1 → 0x7FC0; 0xFF80 → 0x0000.
- Stream 8 back-to-back inputs, ready_i low for cycles 3–5 → ready_o drops once pipe full, res_o stable while stalled, all 8 outputs in order, none lost or duplicated.
- Pipe full and clear_i=1 with valid_i=1 → next cycle valid_o=0, subsequent input emerges normally after PIPE_REGS cycles.
- rst_i asserted asynchronously mid-stream (between edges) → valid_o and res_o go to 0 immediately, stream restarts cleanly after deassert.
